// File: rtl/icache_mshr_pkg.sv
// icache_mshr_pkg: bus commands, memory tag width and MSHR entry types shared by the icache miss controller
package icache_mshr_pkg;
  localparam int MEM_TAG_W = 4;
  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;
  typedef enum logic [1:0] {ST_FREE, ST_ISSUE, ST_WAIT} mshr_state_t;
  typedef struct packed {
    mshr_state_t state;
    logic [63:0] addr;
    logic [MEM_TAG_W-1:0] tag;
  } mshr_entry_t;
  localparam mshr_entry_t ENTRY_RST = '{state: ST_FREE, addr: '0, tag: '0};
endpackage

// File: rtl/icache_mshr_entry.sv
// icache_mshr_entry: one miss entry (FREE/ISSUE/WAIT) holding a block-aligned address and memory tag
module icache_mshr_entry
  import icache_mshr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  input  logic [63:0]          alloc_addr,
  input  logic                 accept,
  input  logic [MEM_TAG_W-1:0] rsp_tag,
  input  logic                 fill,
  input  logic                 flush,
  output mshr_entry_t          ent
);
  mshr_entry_t nxt;
  always_ff @(posedge clk)
    if (rst) ent <= ENTRY_RST;
    else ent <= nxt;
  always_comb begin
    nxt = ent;
    if (ent.state == ST_FREE && alloc) nxt = '{state: ST_ISSUE, addr: alloc_addr, tag: '0};
    if (ent.state == ST_ISSUE && accept) begin
      nxt.state = ST_WAIT;
      nxt.tag = rsp_tag;
    end
    if ((ent.state == ST_ISSUE && flush) || (ent.state == ST_WAIT && fill)) nxt = ENTRY_RST;
  end
endmodule

// File: rtl/icache_mshr_ctrl.sv
// icache_mshr_ctrl: icache miss controller with NUM_MSHR outstanding misses, next-line prefetch, fill and bypass
module icache_mshr_ctrl
  import icache_mshr_pkg::*;
#(
  parameter int NUM_MSHR = 4,
  parameter int IDX_W = 5,
  parameter int OFF_W = 3,
  parameter int NL_PFETCH = 1,
  localparam int TAG_W = 64 - IDX_W - OFF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          if2Icache_addr_i,
  input  logic                 if2Icache_flush_i,
  input  logic                 cachemem_hit_i,
  input  logic [63:0]          cachemem_data_i,
  input  logic [MEM_TAG_W-1:0] Imem2proc_response_i,
  input  logic [MEM_TAG_W-1:0] Imem2proc_tag_i,
  input  logic [63:0]          Imem2proc_data_i,
  output logic                 Icache2if_vld_o,
  output logic [63:0]          Icache2if_data_o,
  output logic [IDX_W-1:0]     Ictrl2Icache_rd_idx_o,
  output logic [TAG_W-1:0]     Ictrl2Icache_rd_tag_o,
  output logic                 Ictrl2Icache_wr_en_o,
  output logic [IDX_W-1:0]     Ictrl2Icache_wr_idx_o,
  output logic [TAG_W-1:0]     Ictrl2Icache_wr_tag_o,
  output logic [63:0]          Ictrl2Imem_addr_o,
  output logic [1:0]           Ictrl2Imem_command_o,
  output logic                 mshr_full_o
);
  localparam int IW = $clog2(NUM_MSHR);
  mshr_entry_t ent [NUM_MSHR];
  logic [NUM_MSHR-1:0] fill;
  logic [IW-1:0] f0, f1, iss, fi;
  logic has0, has1, has_iss, held_d, held_n, dem_go, pf_go, acc_go, issue_v, unused_off;
  logic [63:0] dem_addr, nxt_addr, fill_addr;
  assign unused_off = ^if2Icache_addr_i[OFF_W-1:0];
  assign dem_addr = {if2Icache_addr_i[63:OFF_W], OFF_W'(0)};
  assign nxt_addr = dem_addr + (64'(1) << OFF_W);
  assign Ictrl2Icache_rd_idx_o = if2Icache_addr_i[OFF_W +: IDX_W];
  assign Ictrl2Icache_rd_tag_o = if2Icache_addr_i[63 -: TAG_W];
  always_comb begin
    {f0, f1, iss, fi} = '0;
    {has0, has1, has_iss, held_d, held_n} = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (ent[i].state == ST_FREE) begin
        f1 = f0;
        has1 = has0;
        f0 = IW'(i);
        has0 = 1'b1;
      end
      if (ent[i].state == ST_ISSUE) begin
        iss = IW'(i);
        has_iss = 1'b1;
      end
      if (fill[i]) fi = IW'(i);
      held_d |= ent[i].state != ST_FREE && ent[i].addr == dem_addr;
      held_n |= ent[i].state != ST_FREE && ent[i].addr == nxt_addr;
    end
  end
  assign dem_go = !rst && !cachemem_hit_i && !if2Icache_flush_i && !held_d && has0;
  assign pf_go = NL_PFETCH != 0 && dem_go && has1 && !held_n;
  assign issue_v = !rst && !if2Icache_flush_i && has_iss;
  assign acc_go = issue_v && |Imem2proc_response_i;
  for (genvar i = 0; i < NUM_MSHR; i++) begin : g_ent
    logic pf;
    assign pf = pf_go && f1 == IW'(i);
    assign fill[i] = ent[i].state == ST_WAIT && ent[i].tag == Imem2proc_tag_i && |Imem2proc_tag_i;
    icache_mshr_entry u_ent (
      .clk        (clk),
      .rst        (rst),
      .alloc      ((dem_go && f0 == IW'(i)) || pf),
      .alloc_addr (pf ? nxt_addr : dem_addr),
      .accept     (acc_go && iss == IW'(i)),
      .rsp_tag    (Imem2proc_response_i),
      .fill       (fill[i] && !rst),
      .flush      (if2Icache_flush_i),
      .ent        (ent[i])
    );
  end
  assign fill_addr = ent[fi].addr;
  assign Ictrl2Icache_wr_en_o = !rst && |fill;
  assign Ictrl2Icache_wr_idx_o = fill_addr[OFF_W +: IDX_W];
  assign Ictrl2Icache_wr_tag_o = fill_addr[63 -: TAG_W];
  assign Ictrl2Imem_command_o = issue_v ? BUS_LOAD : BUS_NONE;
  assign Ictrl2Imem_addr_o = issue_v ? ent[iss].addr : '0;
  assign mshr_full_o = !rst && !has0;
  assign Icache2if_vld_o = cachemem_hit_i || (Ictrl2Icache_wr_en_o && fill_addr == dem_addr);
  assign Icache2if_data_o = cachemem_hit_i ? cachemem_data_i : Imem2proc_data_i;
endmodule

// File: tb/tb_icache_mshr_ctrl.sv
// tb_icache_mshr_ctrl: vector table and scoreboard bench for icache_mshr_ctrl with and without next-line prefetch
module tb_icache_mshr_ctrl;
  localparam int IDX_W = 5;
  localparam int OFF_W = 3;
  localparam int TAG_W = 56;
  localparam logic [1:0] NONE = 2'h0;
  localparam logic [1:0] LOAD = 2'h1;
  localparam logic [63:0] CDATA = 64'hC0DE_0000_1111_2222;
  localparam logic [63:0] MDATA = 64'hFEED_3333_4444_5555;
  typedef struct {
    logic sel;
    logic rst;
    logic [63:0] addr;
    logic flush;
    logic hit;
    logic [3:0] rsp;
    logic [3:0] mtag;
    logic vld;
    logic [1:0] cmd;
    logic [63:0] maddr;
    logic wr;
    logic [63:0] waddr;
    logic full;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, hit = 1'b0;
  logic [63:0] addr = '0, cdata = CDATA, mdata = MDATA;
  logic [3:0] rsp = '0, mtag = '0;
  logic vld, wr, full, n_vld, n_wr, n_full;
  logic [63:0] data, maddr, n_data, n_maddr;
  logic [IDX_W-1:0] rd_idx, wr_idx, n_rd_idx, n_wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag, n_rd_tag, n_wr_tag;
  logic [1:0] cmd, n_cmd;
  vec_t exp_q[$];
  vec_t tbl[$];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  icache_mshr_ctrl dut (
    .clk(clk), .rst(rst), .if2Icache_addr_i(addr), .if2Icache_flush_i(flush),
    .cachemem_hit_i(hit), .cachemem_data_i(cdata), .Imem2proc_response_i(rsp),
    .Imem2proc_tag_i(mtag), .Imem2proc_data_i(mdata), .Icache2if_vld_o(vld),
    .Icache2if_data_o(data), .Ictrl2Icache_rd_idx_o(rd_idx), .Ictrl2Icache_rd_tag_o(rd_tag),
    .Ictrl2Icache_wr_en_o(wr), .Ictrl2Icache_wr_idx_o(wr_idx), .Ictrl2Icache_wr_tag_o(wr_tag),
    .Ictrl2Imem_addr_o(maddr), .Ictrl2Imem_command_o(cmd), .mshr_full_o(full)
  );
  icache_mshr_ctrl #(.NL_PFETCH(0)) dut_np (
    .clk(clk), .rst(rst), .if2Icache_addr_i(addr), .if2Icache_flush_i(flush),
    .cachemem_hit_i(hit), .cachemem_data_i(cdata), .Imem2proc_response_i(rsp),
    .Imem2proc_tag_i(mtag), .Imem2proc_data_i(mdata), .Icache2if_vld_o(n_vld),
    .Icache2if_data_o(n_data), .Ictrl2Icache_rd_idx_o(n_rd_idx), .Ictrl2Icache_rd_tag_o(n_rd_tag),
    .Ictrl2Icache_wr_en_o(n_wr), .Ictrl2Icache_wr_idx_o(n_wr_idx), .Ictrl2Icache_wr_tag_o(n_wr_tag),
    .Ictrl2Imem_addr_o(n_maddr), .Ictrl2Imem_command_o(n_cmd), .mshr_full_o(n_full)
  );
  function automatic vec_t v(input logic s, r, input logic [63:0] a, input logic f, h,
                             input logic [3:0] rs, tg, input logic ev, input logic [1:0] ec,
                             input logic [63:0] ema, input logic ew, input logic [63:0] ewa,
                             input logic ef);
    vec_t x;
    x.sel = s; x.rst = r; x.addr = a; x.flush = f; x.hit = h; x.rsp = rs; x.mtag = tg;
    x.vld = ev; x.cmd = ec; x.maddr = ema; x.wr = ew; x.waddr = ewa; x.full = ef;
    return x;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at vector %0d: got %h, expected %h", nm, n_vec, got, want);
    end
  endtask
  task automatic step(input vec_t x);
    @(posedge clk);
    #1;
    rst = x.rst; addr = x.addr; flush = x.flush; hit = x.hit; rsp = x.rsp; mtag = x.mtag;
    exp_q.push_back(x);
  endtask
  always @(negedge clk) begin : mon
    vec_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      chk("vld", 64'(e.sel ? n_vld : vld), 64'(e.vld));
      if (e.vld) chk("data", e.sel ? n_data : data, e.hit ? CDATA : MDATA);
      chk("rd_idx", 64'(e.sel ? n_rd_idx : rd_idx), 64'(e.addr[7:3]));
      chk("rd_tag", 64'(e.sel ? n_rd_tag : rd_tag), 64'(e.addr[63:8]));
      chk("command", 64'(e.sel ? n_cmd : cmd), 64'(e.cmd));
      if (e.cmd == LOAD) chk("mem_addr", e.sel ? n_maddr : maddr, e.maddr);
      chk("wr_en", 64'(e.sel ? n_wr : wr), 64'(e.wr));
      if (e.wr) begin
        chk("wr_idx", 64'(e.sel ? n_wr_idx : wr_idx), 64'(e.waddr[7:3]));
        chk("wr_tag", 64'(e.sel ? n_wr_tag : wr_tag), 64'(e.waddr[63:8]));
      end
      chk("mshr_full", 64'(e.sel ? n_full : full), 64'(e.full));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tbl.push_back(v(0, 1, 0,       0, 0, 0, 0, 0, NONE, 0,       0, 0,       0));
    tbl.push_back(v(0, 0, 'h1000,  0, 0, 0, 0, 0, NONE, 0,       0, 0,       0));
    tbl.push_back(v(0, 0, 'h1000,  0, 0, 3, 0, 0, LOAD, 'h1000,  0, 0,       0));
    tbl.push_back(v(0, 0, 'h1000,  0, 0, 4, 0, 0, LOAD, 'h1008,  0, 0,       0));
    tbl.push_back(v(0, 0, 'h1000,  0, 0, 0, 3, 1, NONE, 0,       1, 'h1000,  0));
    tbl.push_back(v(0, 0, 'h1000,  0, 1, 0, 4, 1, NONE, 0,       1, 'h1008,  0));
    tbl.push_back(v(0, 0, 'h1000,  0, 1, 0, 7, 1, NONE, 0,       0, 0,       0));
    tbl.push_back(v(1, 1, 0,       0, 0, 0, 0, 0, NONE, 0,       0, 0,       0));
    tbl.push_back(v(1, 0, 'h2000,  0, 0, 0, 0, 0, NONE, 0,       0, 0,       0));
    tbl.push_back(v(1, 0, 'h3000,  0, 0, 1, 0, 0, LOAD, 'h2000,  0, 0,       0));
    tbl.push_back(v(1, 0, 'h4000,  0, 0, 2, 0, 0, LOAD, 'h3000,  0, 0,       0));
    tbl.push_back(v(1, 0, 'h5000,  0, 0, 3, 0, 0, LOAD, 'h4000,  0, 0,       0));
    tbl.push_back(v(1, 0, 'h6000,  0, 0, 4, 0, 0, LOAD, 'h5000,  0, 0,       1));
    tbl.push_back(v(1, 0, 'h6000,  0, 0, 0, 2, 0, NONE, 0,       1, 'h3000,  1));
    tbl.push_back(v(1, 0, 'h6000,  0, 0, 0, 0, 0, NONE, 0,       0, 0,       0));
    tbl.push_back(v(1, 0, 'h6000,  0, 0, 0, 0, 0, LOAD, 'h6000,  0, 0,       1));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    step(v(0, 1, 0,      0, 0, 0, 0, 0, NONE, 0,      0, 0,      0));
    step(v(0, 0, 'h1000, 0, 0, 0, 0, 0, NONE, 0,      0, 0,      0));
    step(v(0, 0, 'h1000, 0, 1, 5, 0, 1, LOAD, 'h1000, 0, 0,      0));
    step(v(0, 0, 'h1000, 1, 1, 6, 0, 1, NONE, 0,      0, 0,      0));
    step(v(0, 0, 'h1000, 0, 1, 6, 0, 1, NONE, 0,      0, 0,      0));
    step(v(0, 0, 'h9000, 0, 1, 0, 5, 1, NONE, 0,      1, 'h1000, 0));
    step(v(0, 0, 'h9000, 0, 1, 0, 0, 1, NONE, 0,      0, 0,      0));
    step(v(0, 1, 0,      0, 0, 0, 0, 0, NONE, 0,      0, 0,      0));
    step(v(0, 0, 'h4000, 0, 0, 0, 0, 0, NONE, 0,      0, 0,      0));
    for (int i = 0; i < 3; i++) step(v(0, 0, 'h4000, 0, 1, 0, 0, 1, LOAD, 'h4000, 0, 0, 0));
    step(v(0, 0, 'h4000, 0, 1, 6, 0, 1, LOAD, 'h4000, 0, 0,      0));
    step(v(0, 0, 'h4000, 0, 1, 0, 0, 1, LOAD, 'h4008, 0, 0,      0));
    step(v(0, 1, 'h4000, 0, 0, 0, 6, 0, NONE, 0,      0, 0,      0));
    step(v(0, 0, 'h4000, 0, 1, 0, 6, 1, NONE, 0,      0, 0,      0));
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors still queued, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
